ncl_mult_seq: RTL and testbench

- Parametrised, clocked successor to the fixed 3x3 NCL multiplier.
- Accepts two WIDTH-bit dual-rail operands under NULL/DATA four-phase handshaking and computes the product iteratively (shift-add, one partial product per clock).
- Returns a 2*WIDTH-bit dual-rail product with return-to-NULL.
- Sits at the boundary between NCL pipeline stages and clocked logic; the handshake semantics on ko/ki match the existing NCL registers.

---
 rtl/ncl_mult_seq.sv | 156 +++++++++++++++
 tb/tb_ncl_mult_seq.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ncl_mult_seq.sv
// Clocked shift-add multiplier with NCL dual-rail four-phase handshaking on both sides.
// Operands are captured when complete; the product is presented as one DATA word, then returned to NULL.
module ncl_mult_seq #(
  parameter int WIDTH       = 3,
  parameter int SIGNED_MODE = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   a_rail1,
  input  logic [WIDTH-1:0]   a_rail0,
  input  logic [WIDTH-1:0]   b_rail1,
  input  logic [WIDTH-1:0]   b_rail0,
  input  logic               ki,
  output logic [2*WIDTH-1:0] p_rail1,
  output logic [2*WIDTH-1:0] p_rail0,
  output logic               ko,
  output logic               busy,
  output logic               err
);

  localparam int PW = 2 * WIDTH;
  localparam int VW = 4 * WIDTH + 1;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] S_WAIT_DATA   = 3'd0;
  localparam logic [2:0] S_COMPUTE     = 3'd1;
  localparam logic [2:0] S_WAIT_KI1    = 3'd2;
  localparam logic [2:0] S_WAIT_KI0    = 3'd3;
  localparam logic [2:0] S_WAIT_INNULL = 3'd4;

  logic [VW-1:0] w_raw;
  logic [VW-1:0] w_sync;

  assign w_raw = {ki, b_rail0, b_rail1, a_rail0, a_rail1};

  // Each rail is synchronised independently; monotonic NCL transitions make this safe.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_sync = w_raw;
    end else begin : g_sync
      logic [VW-1:0] r_sync [SYNC_STAGES];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
          r_sync[0] <= w_raw;
          for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
      end
      assign w_sync = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  logic [WIDTH-1:0] w_a1, w_a0, w_b1, w_b0;
  logic             w_ki;
  logic [PW-1:0]    w_r1, w_r0;
  logic             w_complete, w_vnull, w_illegal;

  assign w_a1 = w_sync[WIDTH-1:0];
  assign w_a0 = w_sync[2*WIDTH-1:WIDTH];
  assign w_b1 = w_sync[3*WIDTH-1:2*WIDTH];
  assign w_b0 = w_sync[4*WIDTH-1:3*WIDTH];
  assign w_ki = w_sync[4*WIDTH];

  assign w_r1       = {w_a1, w_b1};
  assign w_r0       = {w_a0, w_b0};
  assign w_complete = &(w_r1 ^ w_r0);
  assign w_vnull    = ~|(w_r1 | w_r0);
  assign w_illegal  = |(w_r1 & w_r0);

  logic [2:0]       r_state;
  logic [WIDTH-1:0] r_a, r_b;
  logic [PW-1:0]    r_acc;
  logic [CW-1:0]    r_count;
  logic             r_null_seen;
  logic [PW-1:0]    r_p1, r_p0;
  logic             r_ko, r_busy, r_err;

  logic [PW-1:0] w_aext, w_term, w_acc_next;
  logic          w_bbit, w_last;

  // In signed mode the MSB partial product carries negative weight, so it is subtracted.
  assign w_aext     = (SIGNED_MODE != 0) ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
  assign w_bbit     = |(r_b & (WIDTH'(1) << r_count));
  assign w_term     = (w_aext << r_count) & {PW{w_bbit}};
  assign w_last     = (r_count == CW'(WIDTH - 1));
  assign w_acc_next = ((SIGNED_MODE != 0) && w_last) ? (r_acc - w_term) : (r_acc + w_term);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_WAIT_DATA;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_count     <= '0;
      r_null_seen <= 1'b0;
      r_p1        <= '0;
      r_p0        <= '0;
      r_ko        <= 1'b1;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_illegal) r_err <= 1'b1;
      if (r_state != S_WAIT_DATA && w_vnull) r_null_seen <= 1'b1;
      case (r_state)
        S_WAIT_DATA: begin
          if (w_complete && !w_illegal) begin
            r_a         <= w_a1;
            r_b         <= w_b1;
            r_acc       <= '0;
            r_count     <= '0;
            r_null_seen <= 1'b0;
            r_ko        <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_COMPUTE;
          end
        end
        S_COMPUTE: begin
          r_acc   <= w_acc_next;
          r_count <= r_count + CW'(1);
          if (w_last) r_state <= S_WAIT_KI1;
        end
        S_WAIT_KI1: begin
          if (w_ki) begin
            r_p1    <= r_acc;
            r_p0    <= ~r_acc;
            r_state <= S_WAIT_KI0;
          end
        end
        S_WAIT_KI0: begin
          if (!w_ki) begin
            r_p1    <= '0;
            r_p0    <= '0;
            r_state <= S_WAIT_INNULL;
          end
        end
        S_WAIT_INNULL: begin
          if (r_null_seen || w_vnull) begin
            r_ko    <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_WAIT_DATA;
          end
        end
        default: r_state <= S_WAIT_DATA;
      endcase
    end
  end

  assign p_rail1 = r_p1;
  assign p_rail0 = r_p0;
  assign ko      = r_ko;
  assign busy    = r_busy;
  assign err     = r_err;

endmodule

// File: tb/tb_ncl_mult_seq.sv
// Bench for ncl_mult_seq: unsigned and signed instances share stimulus and are checked
// against plain-arithmetic products and the handshake timing rules.
module tb_ncl_mult_seq;

  localparam int W  = 3;
  localparam int PW = 2 * W;
  localparam int SS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [W-1:0]  a1, a0, b1, b0;
  logic          ki;
  logic [PW-1:0] pu1, pu0, ps1, ps0;
  logic          kou, busyu, erru, kos, busys, errs;

  int checks = 0;
  int errors = 0;

  ncl_mult_seq #(.WIDTH(W), .SIGNED_MODE(0), .SYNC_STAGES(SS)) dut_u (
    .clk(clk), .rst(rst),
    .a_rail1(a1), .a_rail0(a0), .b_rail1(b1), .b_rail0(b0),
    .ki(ki), .p_rail1(pu1), .p_rail0(pu0),
    .ko(kou), .busy(busyu), .err(erru)
  );

  ncl_mult_seq #(.WIDTH(W), .SIGNED_MODE(1), .SYNC_STAGES(SS)) dut_s (
    .clk(clk), .rst(rst),
    .a_rail1(a1), .a_rail0(a0), .b_rail1(b1), .b_rail0(b0),
    .ki(ki), .p_rail1(ps1), .p_rail0(ps0),
    .ko(kos), .busy(busys), .err(errs)
  );

  function automatic logic [PW-1:0] model_u(input logic [W-1:0] a, input logic [W-1:0] b);
    int p;
    p = int'(a) * int'(b);
    return PW'(p);
  endfunction

  function automatic logic [PW-1:0] model_s(input logic [W-1:0] a, input logic [W-1:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return PW'(p);
  endfunction

  task automatic drive_data(input logic [W-1:0] a, input logic [W-1:0] b);
    a1 = a; a0 = ~a; b1 = b; b0 = ~b;
  endtask

  task automatic drive_null();
    a1 = '0; a0 = '0; b1 = '0; b0 = '0;
  endtask

  task automatic wait_ko(input logic lvl, output int n, output bit ok);
    n = 0; ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); n++;
      if (kou === lvl) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_pdata(output int n, output bit ok);
    n = 0; ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); n++;
      if ((pu1 | pu0) !== '0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_pnull(output int n, output bit ok);
    n = 0; ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); n++;
      if ((pu1 | pu0) === '0) begin ok = 1'b1; break; end
    end
  endtask

  // Full four-phase transaction with ki held high; checks products, rails and timing.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit early, input string nm);
    logic [PW-1:0] eu, es;
    int n; bit ok;
    eu = model_u(a, b);
    es = model_s(a, b);
    drive_data(a, b);
    ki = 1'b1;
    wait_ko(1'b0, n, ok);
    checks++;
    if (!ok) begin
      errors++; $display("[TB] FAIL %s ko_fall: timeout, ko=%b required 0", nm, kou);
      return;
    end
    checks++;
    if (busyu !== 1'b1 || busys !== 1'b1) begin
      errors++; $display("[TB] FAIL %s busy: got %b/%b required 1", nm, busyu, busys);
    end
    if (early) drive_null();
    wait_pdata(n, ok);
    checks++;
    if (!ok) begin
      errors++; $display("[TB] FAIL %s data_wait: timeout, p_rail1=%h", nm, pu1);
      return;
    end
    checks++;
    if (n !== W + 1) begin
      errors++; $display("[TB] FAIL %s latency: got %0d cycles required %0d", nm, n, W + 1);
    end
    checks++;
    if (pu1 !== eu || pu0 !== ~eu) begin
      errors++; $display("[TB] FAIL %s prod_u: got r1=%h r0=%h required r1=%h r0=%h", nm, pu1, pu0, eu, ~eu);
    end
    checks++;
    if (ps1 !== es || ps0 !== ~es) begin
      errors++; $display("[TB] FAIL %s prod_s: got r1=%h r0=%h required r1=%h r0=%h", nm, ps1, ps0, es, ~es);
    end
    checks++;
    if (kou !== 1'b0) begin
      errors++; $display("[TB] FAIL %s ko_hold_data: got %b required 0", nm, kou);
    end
    ki = 1'b0;
    drive_null();
    wait_pnull(n, ok);
    checks++;
    if (!ok) begin
      errors++; $display("[TB] FAIL %s null_wait: timeout, p_rail1=%h p_rail0=%h", nm, pu1, pu0);
      return;
    end
    checks++;
    if (kou !== 1'b0 || (ps1 | ps0) !== '0) begin
      errors++; $display("[TB] FAIL %s ko_at_null: got ko=%b ps=%h/%h required ko=0 ps=0", nm, kou, ps1, ps0);
    end
    wait_ko(1'b1, n, ok);
    checks++;
    if (!ok || busyu !== 1'b0) begin
      errors++; $display("[TB] FAIL %s ko_return: got ko=%b busy=%b required ko=1 busy=0", nm, kou, busyu);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ki = 1'b0; drive_null();
    repeat (2) @(negedge clk);
    checks++;
    if (pu1 !== '0 || pu0 !== '0 || kou !== 1'b1 || busyu !== 1'b0 || erru !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: got p=%h/%h ko=%b busy=%b err=%b required 0/0 1 0 0", pu1, pu0, kou, busyu, erru);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int n; bit ok;
    drive_data(3'd7, 3'd7);
    ki = 1'b1;
    wait_ko(1'b0, n, ok);
    checks++;
    if (!ok || n !== SS + 1) begin
      errors++; $display("[TB] FAIL capture_latency: got %0d cycles (ok=%b) required %0d", n, ok, SS + 1);
    end
    wait_pdata(n, ok);
    checks++;
    if (pu1 !== 6'b110001 || pu0 !== 6'b001110) begin
      errors++; $display("[TB] FAIL basic_7x7: got r1=%b r0=%b required r1=110001 r0=001110", pu1, pu0);
    end
    ki = 1'b0;
    drive_null();
    wait_pnull(n, ok);
    wait_ko(1'b1, n, ok);
    checks++;
    if (!ok) begin
      errors++; $display("[TB] FAIL basic_ko_return: ko=%b required 1", kou);
    end
  endtask

  task automatic test_back_to_back();
    run_op(3'd5, 3'd3, 1'b0, "b2b_5x3");
    run_op(3'd0, 3'd6, 1'b0, "b2b_0x6");
  endtask

  task automatic test_signed();
    run_op(3'b100, 3'b011, 1'b0, "signed_m4x3");
    run_op(3'b100, 3'b100, 1'b1, "signed_m4xm4");
  endtask

  task automatic test_illegal();
    a1 = 3'b101 | 3'b010; a0 = 3'b010 | 3'b010; b1 = 3'b011; b0 = 3'b100;
    ki = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (erru !== 1'b1 || errs !== 1'b1 || kou !== 1'b1 || busyu !== 1'b0) begin
      errors++; $display("[TB] FAIL illegal_hold: got err=%b ko=%b busy=%b required err=1 ko=1 busy=0", erru, kou, busyu);
    end
    run_op(3'b101, 3'b011, 1'b0, "illegal_fixed");
    checks++;
    if (erru !== 1'b1) begin
      errors++; $display("[TB] FAIL illegal_sticky: got err=%b required 1", erru);
    end
  endtask

  task automatic test_ki_hold();
    logic [PW-1:0] eu;
    int n; bit ok;
    eu = model_u(3'd6, 3'd5);
    drive_data(3'd6, 3'd5);
    ki = 1'b0;
    wait_ko(1'b0, n, ok);
    drive_null();
    repeat (15) @(negedge clk);
    checks++;
    if (pu1 !== '0 || pu0 !== '0 || busyu !== 1'b1 || kou !== 1'b0) begin
      errors++; $display("[TB] FAIL ki_hold_null: got p=%h/%h busy=%b ko=%b required 0/0 1 0", pu1, pu0, busyu, kou);
    end
    ki = 1'b1;
    wait_pdata(n, ok);
    checks++;
    if (!ok || n > SS + 1 || pu1 !== eu || pu0 !== ~eu) begin
      errors++; $display("[TB] FAIL ki_release: got %0d cycles r1=%h required <=%0d cycles r1=%h", n, pu1, SS + 1, eu);
    end
    ki = 1'b0;
    wait_pnull(n, ok);
    checks++;
    if (!ok || kou !== 1'b0) begin
      errors++; $display("[TB] FAIL ki_null_drive: got ko=%b required 0", kou);
    end
    @(negedge clk);
    checks++;
    if (kou !== 1'b1 || busyu !== 1'b0) begin
      errors++; $display("[TB] FAIL ki_ko_next_edge: got ko=%b busy=%b required 1 0", kou, busyu);
    end
  endtask

  task automatic test_reset_mid();
    int n; bit ok;
    drive_data(3'd7, 3'd6);
    ki = 1'b1;
    wait_ko(1'b0, n, ok);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (pu1 !== '0 || pu0 !== '0 || kou !== 1'b1 || busyu !== 1'b0 || erru !== 1'b0 || kos !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_mid: got p=%h/%h ko=%b busy=%b err=%b required 0/0 1 0 0", pu1, pu0, kou, busyu, erru);
    end
    drive_null();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    run_op(3'd7, 3'd6, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      run_op(W'($urandom_range(0, 7)), W'($urandom_range(0, 7)), bit'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_signed();
    test_ki_hold();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
